pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32I pipeline. Drives the

---
 rtl/pipeline_hazard_ctrl.sv | 112 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use, redirect and dmem-wait control.
// Define FORWARDING_EN when the EX/MEM/WB bypass network exists; otherwise every in-flight writer stalls ID.
module pipeline_hazard_ctrl #(
   parameter int CNT_W        = 32,
   parameter int MAX_MEM_WAIT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic             id_valid,
   input  logic [4:0]       ex_rd,
   input  logic             ex_reg_we,
   input  logic             ex_is_load,
   input  logic [4:0]       mem_rd,
   input  logic             mem_reg_we,
   input  logic [4:0]       wb_rd,
   input  logic             wb_reg_we,
   input  logic             ex_redirect,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             mem_timeout
);

   localparam int WW = $clog2(MAX_MEM_WAIT + 1);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t        state;
   logic [WW-1:0] wait_cnt;
   logic          rs1_hit, rs2_hit, hazard, freeze;

`ifdef FORWARDING_EN
   // Only a load in EX cannot be bypassed to ID's consumer.
   assign rs1_hit = ex_reg_we & ex_is_load & (ex_rd == id_rs1);
   assign rs2_hit = ex_reg_we & ex_is_load & (ex_rd == id_rs2);
   logic unused_fwd;
   assign unused_fwd = ^{mem_rd, mem_reg_we, wb_rd, wb_reg_we};
`else
   assign rs1_hit = (ex_reg_we  & (ex_rd  == id_rs1))
                  | (mem_reg_we & (mem_rd == id_rs1))
                  | (wb_reg_we  & (wb_rd  == id_rs1));
   assign rs2_hit = (ex_reg_we  & (ex_rd  == id_rs2))
                  | (mem_reg_we & (mem_rd == id_rs2))
                  | (wb_reg_we  & (wb_rd  == id_rs2));
   logic unused_fwd;
   assign unused_fwd = ex_is_load;
`endif

   assign hazard = id_valid & ((id_rs1_used & rs1_hit & (id_rs1 != 5'd0))
                             | (id_rs2_used & rs2_hit & (id_rs2 != 5'd0)));

   // The ready cycle out of MEM_WAIT is treated as plain RUN so held work proceeds.
   assign freeze = (state == RUN) ? (dmem_req & ~dmem_ready) : ~dmem_ready;

   always_comb begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (rst) begin
         {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (freeze) begin
         {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      end else if (ex_redirect) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (hazard) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         wait_cnt     <= '0;
         stall_cycles <= '0;
         mem_timeout  <= 1'b0;
      end else begin
         if (!pc_en && stall_cycles != {CNT_W{1'b1}})
            stall_cycles <= stall_cycles + 1'b1;
         if (freeze) begin
            state <= MEM_WAIT;
            if (wait_cnt != WW'(MAX_MEM_WAIT))
               wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt >= WW'(MAX_MEM_WAIT - 1))
               mem_timeout <= 1'b1;
         end else if (state == MEM_WAIT) begin
            state    <= RUN;
            wait_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected outputs queued per step, checked mid-cycle.
module tb_pipeline_hazard_ctrl;

`ifdef FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   localparam logic [4:0] EN_ALL  = 5'b11111;
   localparam logic [4:0] EN_HAZ  = 5'b00111;
   localparam logic [4:0] EN_NONE = 5'b00000;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
   logic       id_rs1_used, id_rs2_used, id_valid;
   logic       ex_reg_we, ex_is_load, mem_reg_we, wb_reg_we;
   logic       ex_redirect, dmem_req, dmem_ready;
   logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic       ifid_flush, idex_flush, mem_timeout;
   logic [3:0] stall_cycles;

   typedef struct packed {
      logic [4:0] en;
      logic [1:0] fl;
      logic [3:0] st;
      logic       to;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   logic [3:0] exp_stall = 4'd0;

   pipeline_hazard_ctrl #(.CNT_W(4), .MAX_MEM_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_valid(id_valid),
      .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load),
      .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
      .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
      .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
      id_valid = 1'b0; ex_rd = 5'd0; ex_reg_we = 1'b0; ex_is_load = 1'b0;
      mem_rd = 5'd0; mem_reg_we = 1'b0; wb_rd = 5'd0; wb_reg_we = 1'b0;
      ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic load_use(input logic [4:0] r);
      id_valid = 1'b1; id_rs1 = r; id_rs1_used = 1'b1;
      ex_rd = r; ex_reg_we = 1'b1; ex_is_load = 1'b1;
   endtask

   task automatic check(input string tag);
      exp_t e;
      total++;
      assert (sb.size() != 0) else begin
         bad++;
         $error("FAIL %s: scoreboard empty, got nothing required one entry", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         total++;
         assert ({pc_en, ifid_en, idex_en, exmem_en, memwb_en} === e.en) else begin
            bad++;
            $error("FAIL %s.en: got %b want %b", tag,
                   {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, e.en);
         end
         total++;
         assert ({ifid_flush, idex_flush} === e.fl) else begin
            bad++;
            $error("FAIL %s.flush: got %b want %b", tag, {ifid_flush, idex_flush}, e.fl);
         end
         total++;
         assert (stall_cycles === e.st) else begin
            bad++;
            $error("FAIL %s.stall: got %0d want %0d", tag, stall_cycles, e.st);
         end
         total++;
         assert (mem_timeout === e.to) else begin
            bad++;
            $error("FAIL %s.timeout: got %b want %b", tag, mem_timeout, e.to);
         end
      end
   endtask

   // Inputs are already applied; queue the expectation, check mid-cycle, then advance.
   task automatic step(input string tag, input logic [4:0] en, input logic [1:0] fl,
                       input logic to);
      exp_t e;
      e.en = en; e.fl = fl; e.st = exp_stall; e.to = to;
      sb.push_back(e);
      @(negedge clk);
      check(tag);
      if (rst) exp_stall = 4'd0;
      else if (!en[4] && exp_stall != 4'hF) exp_stall = exp_stall + 4'd1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      step("reset", EN_NONE, 2'b11, 1'b0);
      rst = 1'b0;
      step("normal", EN_ALL, 2'b00, 1'b0);

      load_use(5'd5);
      step("load_use", EN_HAZ, 2'b01, 1'b0);
      idle(); id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1;
      mem_rd = 5'd5; mem_reg_we = 1'b1;
      step("load_in_mem", FWD ? EN_ALL : EN_HAZ, FWD ? 2'b00 : 2'b01, 1'b0);
      idle();
      step("after_load", EN_ALL, 2'b00, 1'b0);

      load_use(5'd0); id_rs2 = 5'd0; id_rs2_used = 1'b1;
      mem_rd = 5'd0; mem_reg_we = 1'b1; wb_rd = 5'd0; wb_reg_we = 1'b1;
      step("x0_dest", EN_ALL, 2'b00, 1'b0);

      idle(); id_valid = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1;
      wb_rd = 5'd7; wb_reg_we = 1'b1;
      step("wb_rs2", FWD ? EN_ALL : EN_HAZ, FWD ? 2'b00 : 2'b01, 1'b0);
      id_rs2_used = 1'b0;
      step("rs2_unused", EN_ALL, 2'b00, 1'b0);
      idle(); load_use(5'd9); id_valid = 1'b0;
      step("id_invalid", EN_ALL, 2'b00, 1'b0);

      load_use(5'd5); ex_redirect = 1'b1;
      step("redirect_haz", EN_ALL, 2'b11, 1'b0);

      idle(); dmem_req = 1'b1;
      step("wait1", EN_NONE, 2'b00, 1'b0);
      dmem_req = 1'b0;
      step("wait2", EN_NONE, 2'b00, 1'b0);
      step("wait3", EN_NONE, 2'b00, 1'b0);
      dmem_ready = 1'b1; dmem_req = 1'b1;
      step("wait_ready", EN_ALL, 2'b00, 1'b0);
      idle();
      step("back_run", EN_ALL, 2'b00, 1'b0);

      load_use(5'd3); ex_redirect = 1'b1; dmem_req = 1'b1;
      step("wait_redir", EN_NONE, 2'b00, 1'b0);
      dmem_ready = 1'b1;
      step("ready_redir", EN_ALL, 2'b11, 1'b0);
      idle();
      step("post_redir", EN_ALL, 2'b00, 1'b0);

      dmem_req = 1'b1;
      for (int i = 1; i <= 10; i++)
         step($sformatf("tmo_wait%0d", i), EN_NONE, 2'b00, i > 4);
      dmem_ready = 1'b1;
      step("tmo_ready", EN_ALL, 2'b00, 1'b1);
      idle();
      step("tmo_sticky", EN_ALL, 2'b00, 1'b1);

      dmem_req = 1'b1;
      step("pre_rst_wait", EN_NONE, 2'b00, 1'b1);
      rst = 1'b1;
      step("rst_in_wait", EN_NONE, 2'b11, 1'b1);
      rst = 1'b0; idle();
      step("post_rst", EN_ALL, 2'b00, 1'b0);
      dmem_req = 1'b1;
      for (int i = 1; i <= 3; i++)
         step($sformatf("rst_wait%0d", i), EN_NONE, 2'b00, 1'b0);
      dmem_ready = 1'b1;
      step("rst_wait_ready", EN_ALL, 2'b00, 1'b0);

      total++;
      assert (sb.size() == 0) else begin
         bad++;
         $error("FAIL sb_drain: got %0d entries left want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
